// File: rtl/axi_read_responder.sv
// AXI read responder: queues AR requests in order, walks each burst's beat
// addresses, reads one word per beat from a synchronous memory and returns it on R.
module axi_read_responder #(
  parameter int ID_WIDTH    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 8,
  parameter int SIZE_WIDTH  = 3,
  parameter int BURST_WIDTH = 2,
  parameter int QOS_WIDTH   = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int AR_DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ar_valid,
  input  logic [ID_WIDTH-1:0]    ar_id,
  input  logic [ADDR_WIDTH-1:0]  ar_addr,
  input  logic [LEN_WIDTH-1:0]   ar_len,
  input  logic [SIZE_WIDTH-1:0]  ar_size,
  input  logic [BURST_WIDTH-1:0] ar_burst,
  input  logic [QOS_WIDTH-1:0]   ar_qos,
  output logic                   ar_ready,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  output logic                   r_valid,
  output logic [ID_WIDTH-1:0]    r_id,
  output logic [DATA_WIDTH-1:0]  r_data,
  output logic [1:0]             r_resp,
  output logic                   r_last,
  input  logic                   r_ready
);

  localparam int PTR_W = $clog2(AR_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]       DEPTH_C  = CNT_W'(AR_DEPTH);
  localparam logic [SIZE_WIDTH-1:0]  MAX_SIZE = SIZE_WIDTH'($clog2(DATA_WIDTH / 8));
  localparam logic [BURST_WIDTH-1:0] B_FIXED  = BURST_WIDTH'(0);
  localparam logic [BURST_WIDTH-1:0] B_INCR   = BURST_WIDTH'(1);
  localparam logic [BURST_WIDTH-1:0] B_WRAP   = BURST_WIDTH'(2);
  localparam logic [BURST_WIDTH-1:0] B_RSVD   = BURST_WIDTH'(3);
  localparam logic [1:0]             RESP_OKAY   = 2'b00;
  localparam logic [1:0]             RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [ID_WIDTH-1:0]    id;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [LEN_WIDTH-1:0]   len;
    logic [SIZE_WIDTH-1:0]  size;
    logic [BURST_WIDTH-1:0] burst;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_RESP} state_t;

  state_t                 r_state, w_state_next;
  req_t                   r_fifo [AR_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic [ID_WIDTH-1:0]    r_cur_id;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [LEN_WIDTH-1:0]   r_len, r_remaining;
  logic [SIZE_WIDTH-1:0]  r_size;
  logic [BURST_WIDTH-1:0] r_burst;
  logic                   r_err;
  logic [DATA_WIDTH-1:0]  r_beat_data;
  logic [1:0]             r_beat_resp;

  logic                   w_push, w_pop, w_last, w_head_err;
  req_t                   w_head, w_req;
  logic [ADDR_WIDTH-1:0]  w_head_mask, w_bytes, w_bmask, w_wrap_mask, w_next_addr;
  logic                   w_unused_qos;

  assign w_unused_qos = ^ar_qos;

  // No bypass: ar_ready looks only at the registered occupancy.
  assign ar_ready = !rst && (r_count < DEPTH_C);
  assign w_push   = ar_valid && ar_ready;
  assign w_pop    = (r_state == S_IDLE) && (r_count != '0);
  assign w_req    = '{id: ar_id, addr: ar_addr, len: ar_len, size: ar_size, burst: ar_burst};
  assign w_head   = r_fifo[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: queue storage is not reset; validity is tracked by the reset pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_req;
  end

  assign w_head_mask = (ADDR_WIDTH'(1) << w_head.size) - ADDR_WIDTH'(1);
  assign w_head_err  = (w_head.burst == B_RSVD) || (w_head.size > MAX_SIZE) ||
                       ((w_head.burst == B_WRAP) &&
                        !((w_head.len == LEN_WIDTH'(1)) || (w_head.len == LEN_WIDTH'(3)) ||
                          (w_head.len == LEN_WIDTH'(7)) || (w_head.len == LEN_WIDTH'(15)))) ||
                       ((w_head.burst == B_WRAP) && ((w_head.addr & w_head_mask) != '0));

  assign w_bytes     = ADDR_WIDTH'(1) << r_size;
  assign w_bmask     = w_bytes - ADDR_WIDTH'(1);
  assign w_wrap_mask = ((ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << r_size) - ADDR_WIDTH'(1);
  assign w_last      = (r_remaining == '0);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_next_addr = r_addr;
    case (r_burst)
      B_INCR:  w_next_addr = (r_addr & ~w_bmask) + w_bytes;
      B_WRAP:  w_next_addr = (r_addr & ~w_wrap_mask) | ((r_addr + w_bytes) & w_wrap_mask);
      B_FIXED: w_next_addr = r_addr;
      default: w_next_addr = r_addr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_pop) w_state_next = w_head_err ? S_RESP : S_FETCH;
      S_FETCH: w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_RESP;
      S_RESP: begin
        if (r_ready) begin
          if (w_last)     w_state_next = S_IDLE;
          else if (r_err) w_state_next = S_RESP;
          else            w_state_next = S_FETCH;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Error bursts preload SLVERR/zero data once; legal beats overwrite it in LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_id    <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_remaining <= '0;
      r_size      <= '0;
      r_burst     <= '0;
      r_err       <= 1'b0;
      r_beat_data <= '0;
      r_beat_resp <= RESP_OKAY;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_cur_id    <= w_head.id;
            r_addr      <= w_head.addr;
            r_len       <= w_head.len;
            r_remaining <= w_head.len;
            r_size      <= w_head.size;
            r_burst     <= w_head.burst;
            r_err       <= w_head_err;
            if (w_head_err) begin
              r_beat_data <= '0;
              r_beat_resp <= RESP_SLVERR;
            end
          end
        end
        S_LOAD: begin
          r_beat_data <= mem_rdata;
          r_beat_resp <= RESP_OKAY;
        end
        S_RESP: begin
          if (r_ready && !w_last) begin
            r_remaining <= r_remaining - LEN_WIDTH'(1);
            r_addr      <= w_next_addr;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req  = (r_state == S_FETCH);
  assign mem_addr = r_addr;
  assign r_valid  = (r_state == S_RESP);
  assign r_last   = r_valid && w_last;
  assign r_id     = r_cur_id;
  assign r_data   = r_beat_data;
  assign r_resp   = r_beat_resp;

endmodule

// File: tb/tb_axi_read_responder.sv
// Bench for axi_read_responder: directed table, hand-written timing sequences,
// and random traffic scored against a burst-level reference model.
module tb_axi_read_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ar_valid = 1'b0;
  logic [3:0]  ar_id = '0;
  logic [31:0] ar_addr = '0;
  logic [7:0]  ar_len = '0;
  logic [2:0]  ar_size = '0;
  logic [1:0]  ar_burst = '0;
  logic [3:0]  ar_qos = '0;
  logic        ar_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [63:0] mem_rdata = '0;
  logic        r_valid;
  logic [3:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        r_ready = 1'b1;

  axi_read_responder #(.AR_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .ar_valid(ar_valid), .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
    .ar_size(ar_size), .ar_burst(ar_burst), .ar_qos(ar_qos), .ar_ready(ar_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .r_valid(r_valid), .r_id(r_id), .r_data(r_data), .r_resp(r_resp),
    .r_last(r_last), .r_ready(r_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          beats;
    int          nmem;
    logic [1:0]  resp;
    logic [31:0] addrs [4];
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  beat_t       exp_q[$];
  logic [31:0] exp_mem_q[$];
  beat_t       beat_log[$];
  logic [31:0] mem_log[$];
  bit          rnd_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a, a ^ 32'hA5A5_5A5A};
  endfunction

  function automatic bit req_is_err(input logic [7:0] len, input logic [2:0] size,
                                    input logic [1:0] burst, input logic [31:0] addr);
    longint unsigned nbytes;
    nbytes = longint'(1) << size;
    if (burst == 2'b11) return 1'b1;
    if (nbytes > 8) return 1'b1;
    if (burst == 2'b10) begin
      if (!(len inside {8'd1, 8'd3, 8'd7, 8'd15})) return 1'b1;
      if ((longint'(addr) % nbytes) != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Byte address of beat i, straight from the burst-type definitions.
  function automatic logic [31:0] beat_addr(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst,
                                            input int i);
    longint unsigned b, w, base, a;
    a = longint'(addr);
    b = longint'(1) << size;
    if (burst == 2'b00 || i == 0) return addr;
    if (burst == 2'b01) return 32'((a / b) * b + longint'(i) * b);
    w = (longint'(len) + 1) * b;
    base = (a / w) * w;
    return 32'(base + ((a - base + longint'(i) * b) % w));
  endfunction

  function automatic void model_push(input logic [3:0] id, input logic [31:0] addr,
                                     input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    bit          err;
    beat_t       e;
    logic [31:0] a;
    err = req_is_err(len, size, burst, addr);
    for (int i = 0; i <= int'(len); i++) begin
      e.id   = id;
      e.resp = err ? 2'b10 : 2'b00;
      e.last = (i == int'(len));
      e.data = '0;
      if (!err) begin
        a = beat_addr(addr, len, size, burst, i);
        e.data = mem_word(a);
        exp_mem_q.push_back(a);
      end
      exp_q.push_back(e);
    end
  endfunction

  // Memory model plus R/mem scoreboard, sampled on the falling edge.
  logic        mem_pend = 1'b0;
  logic [31:0] mem_pend_addr = '0;
  always @(negedge clk) begin : mon
    beat_t       e;
    beat_t       got;
    logic [31:0] a;
    if (rst) begin
      exp_q.delete();
      exp_mem_q.delete();
      mem_pend  = 1'b0;
      mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    end else begin
      if (mem_req) begin
        check("mem_req_expected", 64'(exp_mem_q.size() != 0), 64'(1));
        if (exp_mem_q.size() != 0) begin
          a = exp_mem_q.pop_front();
          check("mem_addr", 64'(mem_addr), 64'(a));
        end
        mem_log.push_back(mem_addr);
      end
      if (r_valid) begin
        check("r_valid_no_mem_req", 64'(mem_req), 64'(0));
        check("r_beat_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          check("r_id", 64'(r_id), 64'(e.id));
          check("r_data", r_data, e.data);
          check("r_resp", 64'(r_resp), 64'(e.resp));
          check("r_last", 64'(r_last), 64'(e.last));
          if (r_ready) void'(exp_q.pop_front());
        end
        if (r_ready) begin
          got = '{id: r_id, data: r_data, resp: r_resp, last: r_last};
          beat_log.push_back(got);
        end
      end
      mem_rdata     = mem_pend ? mem_word(mem_pend_addr) : 64'hDEAD_BEEF_DEAD_BEEF;
      mem_pend      = mem_req;
      mem_pend_addr = mem_addr;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_ready) r_ready = ($urandom_range(0, 3) != 0);
  end

  // Called and returns at posedge+1; keeps ar_valid up until accepted or out of tries.
  task automatic send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst, input int tries,
                      output bit acc);
    acc      = 1'b0;
    ar_id    = id;
    ar_addr  = addr;
    ar_len   = len;
    ar_size  = size;
    ar_burst = burst;
    ar_qos   = 4'($urandom);
    ar_valid = 1'b1;
    for (int t = 0; t < tries && !acc; t++) begin
      @(negedge clk);
      acc = ar_ready;
      if (acc) model_push(id, addr, len, size, burst);
      @(posedge clk);
      #1;
    end
    ar_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!r_valid && n < 60);
    check(name, 64'(r_valid), 64'(1));
  endtask

  task automatic check_outputs_reset(input string tag);
    check({tag, "_ar_ready"}, 64'(ar_ready), 64'(0));
    check({tag, "_mem_req"},  64'(mem_req),  64'(0));
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    check({tag, "_r_valid"},  64'(r_valid),  64'(0));
    check({tag, "_r_id"},     64'(r_id),     64'(0));
    check({tag, "_r_data"},   r_data,        64'(0));
    check({tag, "_r_resp"},   64'(r_resp),   64'(0));
    check({tag, "_r_last"},   64'(r_last),   64'(0));
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  vec_t vecs [11];

  initial begin : stim
    bit          acc;
    bit   [5:0]  accv;
    logic [4:1]  mr_v, rv_v;
    logic [31:0] lat_addr;
    int          total_beats;
    logic [3:0]  rid;
    logic [31:0] raddr;
    logic [7:0]  rlen;
    logic [2:0]  rsize;
    logic [1:0]  rburst;
    logic [7:0]  len_pick [6];

    vecs[0]  = '{4'd5,  32'h0000_0100, 8'd0, 3'd3, 2'b01, 1, 1, 2'b00, '{32'h100, 32'h0, 32'h0, 32'h0}};
    vecs[1]  = '{4'd1,  32'h0000_1000, 8'd3, 3'd3, 2'b01, 4, 4, 2'b00, '{32'h1000, 32'h1008, 32'h1010, 32'h1018}};
    vecs[2]  = '{4'd2,  32'h0000_1018, 8'd3, 3'd3, 2'b10, 4, 4, 2'b00, '{32'h1018, 32'h1000, 32'h1008, 32'h1010}};
    vecs[3]  = '{4'd3,  32'h0000_0020, 8'd2, 3'd3, 2'b00, 3, 3, 2'b00, '{32'h20, 32'h20, 32'h20, 32'h0}};
    vecs[4]  = '{4'd4,  32'h0000_0040, 8'd1, 3'd3, 2'b11, 2, 0, 2'b10, '{32'h0, 32'h0, 32'h0, 32'h0}};
    vecs[5]  = '{4'd6,  32'h0000_0080, 8'd0, 3'd4, 2'b01, 1, 0, 2'b10, '{32'h0, 32'h0, 32'h0, 32'h0}};
    vecs[6]  = '{4'd7,  32'h0000_1000, 8'd2, 3'd3, 2'b10, 3, 0, 2'b10, '{32'h0, 32'h0, 32'h0, 32'h0}};
    vecs[7]  = '{4'd8,  32'h0000_1004, 8'd3, 3'd3, 2'b10, 4, 0, 2'b10, '{32'h0, 32'h0, 32'h0, 32'h0}};
    vecs[8]  = '{4'd9,  32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01, 2, 2, 2'b00, '{32'hFFFF_FFF8, 32'h0, 32'h0, 32'h0}};
    vecs[9]  = '{4'd10, 32'h0000_0103, 8'd2, 3'd1, 2'b01, 3, 3, 2'b00, '{32'h103, 32'h104, 32'h106, 32'h0}};
    vecs[10] = '{4'd11, 32'h0000_0036, 8'd3, 3'd1, 2'b10, 4, 4, 2'b00, '{32'h36, 32'h30, 32'h32, 32'h34}};
    len_pick = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd15};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_reset("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency from idle: handshake in cycle 0, mem_req in 2, r_valid in 4.
    r_ready  = 1'b1;
    ar_id    = 4'd5;
    ar_addr  = 32'h100;
    ar_len   = 8'd0;
    ar_size  = 3'd3;
    ar_burst = 2'b01;
    ar_valid = 1'b1;
    @(negedge clk);
    check("lat_ar_ready", 64'(ar_ready), 64'(1));
    model_push(4'd5, 32'h100, 8'd0, 3'd3, 2'b01);
    @(posedge clk);
    #1 ar_valid = 1'b0;
    lat_addr = '0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      mr_v[c] = mem_req;
      rv_v[c] = r_valid;
      if (c == 2) lat_addr = mem_addr;
    end
    check("lat_mem_req_cycles", 64'(mr_v), 64'(4'b0010));
    check("lat_r_valid_cycles", 64'(rv_v), 64'(4'b1000));
    check("lat_mem_addr", 64'(lat_addr), 64'(32'h100));
    check("lat_r_id", 64'(r_id), 64'(5));
    check("lat_r_last", 64'(r_last), 64'(1));
    check("lat_r_data", r_data, mem_word(32'h100));
    wait_drain("lat_drain", 50);

    // Directed table.
    for (int v = 0; v < 11; v++) begin
      beat_log.delete();
      mem_log.delete();
      send(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, 50, acc);
      check("tbl_accept", 64'(acc), 64'(1));
      wait_drain("tbl_drain", 200);
      repeat (2) @(posedge clk);
      #1;
      check("tbl_beats", 64'(beat_log.size()), 64'(vecs[v].beats));
      check("tbl_mem_reqs", 64'(mem_log.size()), 64'(vecs[v].nmem));
      for (int i = 0; i < vecs[v].nmem && i < mem_log.size(); i++)
        check("tbl_mem_addr", 64'(mem_log[i]), 64'(vecs[v].addrs[i]));
      for (int i = 0; i < beat_log.size(); i++) begin
        check("tbl_resp", 64'(beat_log[i].resp), 64'(vecs[v].resp));
        check("tbl_id", 64'(beat_log[i].id), 64'(vecs[v].id));
        check("tbl_last", 64'(beat_log[i].last), 64'(i == vecs[v].beats - 1));
        if (vecs[v].resp == 2'b10) check("tbl_err_data", beat_log[i].data, 64'(0));
      end
    end

    // INCR burst with a stall on beat 2.
    r_ready = 1'b0;
    send(4'd12, 32'h1000, 8'd3, 3'd3, 2'b01, 50, acc);
    check("stall_accept", 64'(acc), 64'(1));
    for (int b = 0; b < 4; b++) begin
      wait_valid("stall_wait_valid");
      check("stall_data", r_data, mem_word(32'h1000 + 32'(8 * b)));
      check("stall_last", 64'(r_last), 64'(b == 3));
      if (b == 1) begin
        repeat (5) begin
          @(negedge clk);
          check("stall_hold_valid", 64'(r_valid), 64'(1));
          check("stall_hold_data", r_data, mem_word(32'h1008));
          check("stall_hold_id", 64'(r_id), 64'(12));
          check("stall_hold_last", 64'(r_last), 64'(0));
          check("stall_hold_no_mem_req", 64'(mem_req), 64'(0));
        end
      end
      @(posedge clk);
      #1 r_ready = 1'b1;
      @(posedge clk);
      #1 r_ready = 1'b0;
    end
    wait_drain("stall_drain", 50);

    // Queue fill with r_ready low: first request moves to the FSM, four more fill the FIFO.
    beat_log.delete();
    for (int k = 0; k < 6; k++) begin
      send(4'(k + 1), 32'h200 + 32'(k * 64), 8'd1, 3'd3, 2'b01, 1, acc);
      accv[k] = acc;
    end
    check("queue_accept_pattern", 64'(accv), 64'(6'b011111));
    @(negedge clk);
    check("queue_full_ar_ready", 64'(ar_ready), 64'(0));
    @(posedge clk);
    #1 r_ready = 1'b1;
    wait_drain("queue_drain", 200);
    check("queue_beats", 64'(beat_log.size()), 64'(10));
    for (int i = 0; i < beat_log.size() && i < 10; i++)
      check("queue_order_id", 64'(beat_log[i].id), 64'(i / 2 + 1));

    // Reset in the middle of a burst.
    beat_log.delete();
    send(4'd13, 32'h3000, 8'd7, 3'd3, 2'b01, 50, acc);
    for (int n = 0; n < 100 && beat_log.size() < 2; n++) @(posedge clk);
    #1;
    check("midrst_progress", 64'(beat_log.size() >= 2), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outputs_reset("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    beat_log.delete();
    mem_log.delete();
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_beats", 64'(beat_log.size()), 64'(0));
    check("midrst_no_mem_req", 64'(mem_log.size()), 64'(0));

    // Random traffic against the reference model.
    beat_log.delete();
    total_beats = 0;
    rnd_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      rid    = 4'($urandom);
      rsize  = 3'($urandom_range(0, 4));
      rburst = 2'($urandom_range(0, 3));
      rlen   = len_pick[$urandom_range(0, 5)];
      raddr  = $urandom;
      if ($urandom_range(0, 1) == 1) raddr = raddr & ~((32'd1 << rsize) - 32'd1);
      send(rid, raddr, rlen, rsize, rburst, 400, acc);
      check("rnd_accept", 64'(acc), 64'(1));
      if (acc) total_beats += int'(rlen) + 1;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_drain("rnd_drain", 6000);
    rnd_ready = 1'b0;
    @(posedge clk);
    #2 r_ready = 1'b1;
    check("rnd_total_beats", 64'(beat_log.size()), 64'(total_beats));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
